// File: rtl/gba_timer_pkg.sv
// Shared constants for the GBA-style timer bank: ctrl bit positions, prescale
// encodings and divisors.
package gba_timer_pkg;

    localparam int unsigned CTRL_PS   = 0;
    localparam int unsigned CTRL_CASC = 2;
    localparam int unsigned CTRL_IRQ  = 6;
    localparam int unsigned CTRL_EN   = 7;

    // Only these ctrl bits are stored; everything else reads back as 0.
    localparam logic [15:0] CTRL_MASK = 16'h00C7;

    typedef enum logic [1:0] {
        PsDiv1    = 2'b00,
        PsDiv64   = 2'b01,
        PsDiv256  = 2'b10,
        PsDiv1024 = 2'b11
    } presc_sel_e;

    localparam int unsigned DIV_1    = 1;
    localparam int unsigned DIV_64   = 64;
    localparam int unsigned DIV_256  = 256;
    localparam int unsigned DIV_1024 = 1024;

    function automatic int unsigned presc_div(input presc_sel_e sel);
        case (sel)
            PsDiv1:    presc_div = DIV_1;
            PsDiv64:   presc_div = DIV_64;
            PsDiv256:  presc_div = DIV_256;
            default:   presc_div = DIV_1024;
        endcase
    endfunction

endpackage

// File: rtl/gba_timer_channel.sv
// One timer channel: ctrl/reload/count registers, prescaler and the
// combinational overflow event that feeds the next channel's cascade input.
module gba_timer_channel
    import gba_timer_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PRESC_W = 10,
    parameter bit          CASC_OK = 1'b1
) (
    input  logic        clk_mem,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic        write_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  byte_en_i,
    input  logic        casc_i,
    output logic [15:0] ctrl_o,
    output logic [15:0] count_o,
    output logic        ovf_evt_o,
    output logic        irq_set_o
);

    logic [15:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   reload_q, reload_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [15:0]        reload_wide;
    logic               inc;
    logic               ovf_evt;
    logic               presc_wrap;

    always_comb begin
        reload_wide = 16'(reload_q);
        ctrl_d      = ctrl_q;
        if (write_i) begin
            if (byte_en_i[0]) reload_wide[7:0]  = data_i[7:0];
            if (byte_en_i[1]) reload_wide[15:8] = data_i[15:8];
            if (byte_en_i[2]) ctrl_d[7:0]       = data_i[23:16];
            if (byte_en_i[3]) ctrl_d[15:8]      = data_i[31:24];
        end
        ctrl_d   = ctrl_d & CTRL_MASK;
        reload_d = reload_wide[CNT_W-1:0];

        presc_wrap = (32'(presc_q) ==
                      presc_div(presc_sel_e'(ctrl_q[CTRL_PS +: 2])) - 32'd1);
        presc_d = presc_q;
        inc     = 1'b0;
        if (ctrl_q[CTRL_EN]) begin
            if (CASC_OK && ctrl_q[CTRL_CASC]) begin
                inc = casc_i;
            end else if (tick_i) begin
                if (presc_wrap) begin
                    presc_d = '0;
                    inc     = 1'b1;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
        end

        // A reload written in the overflow cycle is the one that gets loaded.
        ovf_evt = inc && (count_q == '1);
        count_d = count_q;
        if (ovf_evt) begin
            count_d = reload_d;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end

        if (write_i && !ctrl_q[CTRL_EN] && ctrl_d[CTRL_EN]) begin
            count_d = reload_d;
            presc_d = '0;
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
        end
    end

    assign ctrl_o    = ctrl_q;
    assign count_o   = 16'(count_q);
    assign ovf_evt_o = ovf_evt;
    assign irq_set_o = ovf_evt && ctrl_q[CTRL_IRQ];

endmodule

// File: rtl/gba_timer_bank.sv
// Bank of GBA-style timers: per-channel instances, cascade chain, sticky irq
// status word and a registered read port.
module gba_timer_bank
    import gba_timer_pkg::*;
#(
    parameter int unsigned N_TIMERS = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PRESC_W  = 10
) (
    input  logic                clk_mem,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [3:0]          addr,
    input  logic [31:0]         data_in,
    input  logic [3:0]          byte_en,
    input  logic                write,
    input  logic                read,
    output logic [31:0]         data_out,
    output logic [N_TIMERS-1:0] ovf,
    output logic [N_TIMERS-1:0] irq_pending,
    output logic                irq
);

    logic [N_TIMERS-1:0] ovf_evt;
    logic [N_TIMERS-1:0] irq_set;
    logic [N_TIMERS-1:0] casc;
    logic [N_TIMERS-1:0] irq_clr;
    logic [N_TIMERS-1:0] ovf_q;
    logic [N_TIMERS-1:0] irq_q, irq_d;
    logic [31:0]         data_out_q, data_out_d;
    logic [15:0]         ctrl_w  [N_TIMERS];
    logic [15:0]         count_w [N_TIMERS];
    logic                sel_status;

    for (genvar i = 0; i < N_TIMERS; i++) begin : g_chan
        if (i == 0) begin : g_head
            assign casc[i] = 1'b0;
        end else begin : g_link
            assign casc[i] = ovf_evt[i-1];
        end

        gba_timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W),
            .CASC_OK (i != 0)
        ) u_chan (
            .clk_mem   (clk_mem),
            .rst_n     (rst_n),
            .tick_i    (tick),
            .write_i   (write && (addr == 4'(i))),
            .data_i    (data_in),
            .byte_en_i (byte_en),
            .casc_i    (casc[i]),
            .ctrl_o    (ctrl_w[i]),
            .count_o   (count_w[i]),
            .ovf_evt_o (ovf_evt[i]),
            .irq_set_o (irq_set[i])
        );
    end

    assign sel_status = (addr == 4'(N_TIMERS));

    always_comb begin
        irq_clr = '0;
        if (write && sel_status && byte_en[0]) begin
            irq_clr = data_in[N_TIMERS-1:0];
        end
        // Set has priority over a clear landing in the same cycle.
        irq_d = (irq_q & ~irq_clr) | irq_set;

        data_out_d = data_out_q;
        if (read) begin
            data_out_d = '0;
            for (int i = 0; i < N_TIMERS; i++) begin
                if (addr == 4'(i)) begin
                    data_out_d = {ctrl_w[i], count_w[i]};
                end
            end
            if (sel_status) begin
                data_out_d = 32'(irq_q);
            end
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= '0;
            irq_q      <= '0;
            data_out_q <= '0;
        end else begin
            ovf_q      <= ovf_evt;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out    = data_out_q;
    assign ovf         = ovf_q;
    assign irq_pending = irq_q;
    assign irq         = |irq_q;

endmodule
